// File: rtl/poly_func_eval.sv
// rtl/poly_func_eval.sv - Sequential Horner polynomial evaluator, signed fixed point
//
// Evaluates y = c[d]*x^d + ... + c[1]*x + c[0] one Horner step per clock.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start_func  level request; sampled in IDLE, must drop before a new run
//   x_in        signed evaluation point, FRAC_W fractional bits
//   degree_in   polynomial degree, clamped to MAX_DEG
//   coef_in     packed signed coefficients, c[k] at [k*DATA_W +: DATA_W]
//   y_out       registered signed result, 2*DATA_W wide, FRAC_W fractional bits
//   func_done   registered result-valid, held until start_func drops
//   overflow    registered sticky overflow of the current evaluation
//   busy        high while in INIT or STEP
module poly_func_eval #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 8,
  parameter int MAX_DEG = 4,
  parameter int SAT_EN  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_func,
  input  logic [DATA_W-1:0]                 x_in,
  input  logic [2:0]                        degree_in,
  input  logic [(MAX_DEG+1)*DATA_W-1:0]     coef_in,
  output logic signed [2*DATA_W-1:0]        y_out,
  output logic                              func_done,
  output logic                              overflow,
  output logic                              busy
);

  localparam int AW = 2 * DATA_W;
  localparam int PW = 3 * DATA_W;

  typedef enum logic [1:0] {IDLE, INIT, STEP, DONE} state_t;

  state_t state;
  state_t next_state;

  logic signed [DATA_W-1:0] x_q;
  logic signed [AW-1:0]     acc;
  logic [2:0]               cnt;

  // Coefficient tables are always 8 deep so a 3-bit index never leaves range;
  // slots above MAX_DEG read as zero and are never selected.
  logic signed [DATA_W-1:0] coef_in_arr [0:7];
  logic signed [DATA_W-1:0] coef_q      [0:7];

  for (genvar g = 0; g < 8; g++) begin : g_coef
    if (g <= MAX_DEG) begin : g_used
      assign coef_in_arr[g] = coef_in[g*DATA_W +: DATA_W];
    end else begin : g_unused
      assign coef_in_arr[g] = '0;
    end
  end

  logic [2:0]               d_eff;
  logic signed [DATA_W-1:0] init_coef;

  assign d_eff     = (degree_in > 3'(MAX_DEG)) ? 3'(MAX_DEG) : degree_in;
  assign init_coef = coef_in_arr[d_eff];

  // One Horner iteration. Everything is carried at 3*DATA_W so the true
  // value is available for both the range checks and the saturation sign.
  logic signed [DATA_W-1:0] step_coef;
  logic signed [PW-1:0]     acc_w;
  logic signed [PW-1:0]     x_w;
  logic signed [PW-1:0]     c_w;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     shifted;
  logic signed [PW-1:0]     sum;
  logic                     prod_ovf;
  logic                     sum_ovf;
  logic                     ovf_now;
  logic signed [AW-1:0]     sat_val;
  logic signed [AW-1:0]     next_acc;

  assign step_coef = coef_q[cnt - 3'd1];
  assign acc_w     = {{DATA_W{acc[AW-1]}}, acc};
  assign x_w       = {{AW{x_q[DATA_W-1]}}, x_q};
  assign c_w       = {{AW{step_coef[DATA_W-1]}}, step_coef};
  assign prod      = acc_w * x_w;
  assign shifted   = prod >>> FRAC_W;
  assign sum       = shifted + c_w;

  // A value fits in AW signed bits when everything from bit AW-1 upward
  // is a copy of the sign.
  assign prod_ovf = !((&shifted[PW-1:AW-1]) || !(|shifted[PW-1:AW-1]));
  assign sum_ovf  = !((&sum[PW-1:AW-1]) || !(|sum[PW-1:AW-1]));
  assign ovf_now  = prod_ovf || sum_ovf;

  assign sat_val = sum[PW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};

  always_comb begin
    next_acc = sum[AW-1:0];
    if (ovf_now && (SAT_EN != 0)) begin
      next_acc = sat_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_func) next_state = INIT;
      INIT:    next_state = (d_eff == 3'd0) ? DONE : STEP;
      STEP:    if (cnt == 3'd1) next_state = DONE;
      DONE:    if (!start_func) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == INIT) || (state == STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      y_out     <= '0;
      func_done <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      case (state)
        INIT: begin
          // Operands are captured here so later input changes cannot
          // disturb the evaluation in flight.
          x_q       <= x_in;
          coef_q    <= coef_in_arr;
          acc       <= {{DATA_W{init_coef[DATA_W-1]}}, init_coef};
          cnt       <= d_eff;
          overflow  <= 1'b0;
          func_done <= 1'b0;
          if (d_eff == 3'd0) begin
            y_out     <= {{DATA_W{init_coef[DATA_W-1]}}, init_coef};
            func_done <= 1'b1;
          end
        end
        STEP: begin
          acc <= next_acc;
          cnt <= cnt - 3'd1;
          if (ovf_now) begin
            overflow <= 1'b1;
          end
          if (cnt == 3'd1) begin
            y_out     <= next_acc;
            func_done <= 1'b1;
          end
        end
        DONE: begin
          if (!start_func) begin
            func_done <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_func_eval.sv
// tb/tb_poly_func_eval.sv - Scoreboard testbench for poly_func_eval (saturating and wrapping)
module tb_poly_func_eval;

  logic         clk;
  logic         rst_n;
  logic         start_func;
  logic [31:0]  x_in;
  logic [2:0]   degree_in;
  logic [159:0] coef_in;

  logic signed [63:0] y_s, y_w;
  logic done_s, done_w, ovf_s, ovf_w, busy_s, busy_w;

  poly_func_eval #(.DATA_W(32), .FRAC_W(8), .MAX_DEG(4), .SAT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start_func(start_func), .x_in(x_in),
    .degree_in(degree_in), .coef_in(coef_in), .y_out(y_s),
    .func_done(done_s), .overflow(ovf_s), .busy(busy_s)
  );

  poly_func_eval #(.DATA_W(32), .FRAC_W(8), .MAX_DEG(4), .SAT_EN(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .start_func(start_func), .x_in(x_in),
    .degree_in(degree_in), .coef_in(coef_in), .y_out(y_w),
    .func_done(done_w), .overflow(ovf_w), .busy(busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] y;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q_s[$];
  exp_t q_w[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference evaluator at 128-bit width with explicit range comparisons.
  function automatic void model(input logic [31:0] x, input logic [159:0] cf, input int d,
                                input bit sat, output logic [63:0] y, output logic ovf);
    logic signed [127:0] mx, mn, a, xv, p, s, cv;
    logic signed [31:0]  c32;
    mx  = 128'sh7FFFFFFFFFFFFFFF;
    mn  = -mx - 1;
    c32 = cf[d*32 +: 32];
    a   = {{96{c32[31]}}, c32};
    xv  = {{96{x[31]}}, x};
    ovf = 1'b0;
    for (int k = d - 1; k >= 0; k--) begin
      c32 = cf[k*32 +: 32];
      cv  = {{96{c32[31]}}, c32};
      p   = (a * xv) >>> 8;
      s   = p + cv;
      if (p > mx || p < mn || s > mx || s < mn) begin
        ovf = 1'b1;
        if (sat) a = (s < 0) ? mn : mx;
        else     a = {{64{s[63]}}, s[63:0]};
      end else begin
        a = s;
      end
    end
    y = a[63:0];
  endfunction

  // Monitors: pop and compare on each rising func_done.
  logic prev_s = 1'b0;
  logic prev_w = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_s && !prev_s) begin
      if (q_s.size() == 0) begin
        check("unexpected_done_sat", 64'd1, 64'd0);
      end else begin
        e = q_s.pop_front();
        check("y_sat", y_s, e.y);
        check("ovf_sat", {63'd0, ovf_s}, {63'd0, e.ovf});
        check("latency_sat", 64'(cyc), 64'(e.due));
      end
    end
    prev_s = done_s;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_w && !prev_w) begin
      if (q_w.size() == 0) begin
        check("unexpected_done_wrap", 64'd1, 64'd0);
      end else begin
        e = q_w.pop_front();
        check("y_wrap", y_w, e.y);
        check("ovf_wrap", {63'd0, ovf_w}, {63'd0, e.ovf});
        check("latency_wrap", 64'(cyc), 64'(e.due));
      end
    end
    prev_w = done_w;
  end

  task automatic run_eval(input logic [31:0] x, input logic [2:0] d, input logic [159:0] cf,
                          input logic [63:0] ys, input logic os,
                          input logic [63:0] yw, input logic ow, input int hold);
    int n;
    int deff;
    exp_t e;
    deff = (d > 3'd4) ? 4 : int'(d);
    @(negedge clk);
    x_in       = x;
    degree_in  = d;
    coef_in    = cf;
    start_func = 1'b1;
    e.due = cyc + 2 + deff;
    e.y = ys; e.ovf = os; q_s.push_back(e);
    e.y = yw; e.ovf = ow; q_w.push_back(e);
    n = 0;
    while (!done_s && n < 20) begin
      @(negedge clk);
      n++;
      if (n >= 2 && !done_s) begin
        // Operands already captured; disturb inputs and start_func.
        x_in       = $urandom;
        coef_in    = {$urandom, $urandom, $urandom, $urandom, $urandom};
        degree_in  = 3'($urandom_range(0, 7));
        start_func = (n == 2) ? 1'b0 : 1'b1;
      end else begin
        start_func = 1'b1;
      end
    end
    if (!done_s) check("done_timeout", 64'd0, 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_done", {63'd0, done_s}, 64'd1);
      check("hold_y", y_s, ys);
    end
    start_func = 1'b0;
    @(negedge clk);
    check("done_clear", {63'd0, done_s}, 64'd0);
    check("y_held", y_s, ys);
    check("ovf_held", {63'd0, ovf_s}, {63'd0, os});
  endtask

  logic [159:0] cf_def;
  logic [159:0] cf_ovf;
  logic [63:0]  yw_ref;
  logic         ow_ref;

  initial begin
    rst_n      = 1'b0;
    start_func = 1'b0;
    x_in       = '0;
    degree_in  = '0;
    coef_in    = '0;
    cf_def = {32'h0, 32'h0, 32'h100, 32'h400, 32'hFFFFFF00};
    cf_ovf = {5{32'h7FFFFFFF}};

    repeat (3) @(negedge clk);
    check("rst_y", y_s, 64'd0);
    check("rst_done", {63'd0, done_s}, 64'd0);
    check("rst_ovf", {63'd0, ovf_s}, 64'd0);
    check("rst_busy", {63'd0, busy_s}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_eval(32'h200, 3'd2, cf_def, 64'hB00, 1'b0, 64'hB00, 1'b0, 0);
    run_eval(32'hFFFFFD00, 3'd2, cf_def, 64'hFFFFFFFFFFFFFC00, 1'b0, 64'hFFFFFFFFFFFFFC00, 1'b0, 0);
    run_eval(32'h200, 3'd0, {128'h0, 32'h1234}, 64'h1234, 1'b0, 64'h1234, 1'b0, 0);
    run_eval(32'h200, 3'd7, {5{32'h100}}, 64'h1F00, 1'b0, 64'h1F00, 1'b0, 0);
    // -255/256 * 0.5 = -127.5 raw units, floors to -128.
    run_eval(32'h80, 3'd1, {96'h0, 32'hFFFFFF01, 32'h0},
             64'hFFFFFFFFFFFFFF80, 1'b0, 64'hFFFFFFFFFFFFFF80, 1'b0, 0);
    model(32'h7FFFFFFF, cf_ovf, 4, 1'b0, yw_ref, ow_ref);
    run_eval(32'h7FFFFFFF, 3'd4, cf_ovf, 64'h7FFFFFFFFFFFFFFF, 1'b1, yw_ref, ow_ref, 0);
    check("wrap_model_ovf", {63'd0, ow_ref}, 64'd1);

    run_eval(32'h200, 3'd2, cf_def, 64'hB00, 1'b0, 64'hB00, 1'b0, 10);
    run_eval(32'h100, 3'd2, cf_def, 64'h400, 1'b0, 64'h400, 1'b0, 0);

    // Reset while cnt = 2 in a degree-4 run.
    @(negedge clk);
    x_in = 32'h200; degree_in = 3'd4; coef_in = {5{32'h100}}; start_func = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy_s}, 64'd1);
    rst_n = 1'b0;
    start_func = 1'b0;
    #1;
    check("midrst_y", y_s, 64'd0);
    check("midrst_done", {63'd0, done_s}, 64'd0);
    check("midrst_ovf", {63'd0, ovf_s}, 64'd0);
    check("midrst_busy", {63'd0, busy_s}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_idle", {63'd0, done_s}, 64'd0);
    end

    run_eval(32'h200, 3'd2, cf_def, 64'hB00, 1'b0, 64'hB00, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("queue_sat_empty", 64'(q_s.size()), 64'd0);
    check("queue_wrap_empty", 64'(q_w.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
